// File: rtl/thermometer2binary.sv
// Pipelined thermometer-to-binary encoder with a malformed-code (bubble) flag; optional error counter under THERMOMETER2BINARY_ERRCNT_EN.
// Latency: two register stages (S1 captures the word at the accepting edge, S2 presents the result after the next edge); one word per cycle.
// Backpressure: out_valid/out_binary/out_error hold until out_ready; in_ready = !s1_valid || s2_load, so a full stalled pipe refuses input.
module thermometer2binary #(
   parameter int    WIDTH          = 4,
   parameter string IMPLEMENTATION = "COUNT",
   localparam int   BW             = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_thermometer,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    out_binary,
   output logic             out_error
`ifdef THERMOMETER2BINARY_ERRCNT_EN
   ,
   input  logic             err_clear,
   output logic [15:0]      err_count
`endif
);

   // Stage 1 state
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_therm_q, s1_therm_d;

   // Stage 2 (output) state
   logic             out_valid_q, out_valid_d;
   logic [BW-1:0]    out_binary_q, out_binary_d;
   logic             out_error_q, out_error_d;

   // Stage load enables: a stage loads when empty or when its content leaves this cycle
   logic s2_load;
   logic s1_load;

   assign s2_load  = !out_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_load;
   assign in_ready = s1_load;

   // Legality: a thermometer code plus one is a power of two, so it shares no bits with itself.
   // The extra top bit keeps the all-ones word from wrapping to zero.
   logic [WIDTH:0] therm_ext;
   logic           enc_err;
   logic [BW-1:0]  enc_bin;

   assign therm_ext = {1'b0, s1_therm_q};
   assign enc_err   = |(therm_ext & (therm_ext + {{WIDTH{1'b0}}, 1'b1}));

   generate
      if (IMPLEMENTATION == "COUNT") begin : g_count
         // Population count of the stage-1 word
         always_comb begin
            enc_bin = '0;
            for (int i = 0; i < WIDTH; i++) begin
               enc_bin = enc_bin + BW'(s1_therm_q[i]);
            end
         end
      end else if (IMPLEMENTATION == "PRIORITY") begin : g_priority
         // Index of the highest set bit plus one; zero word encodes as zero
         always_comb begin
            enc_bin = '0;
            for (int i = 0; i < WIDTH; i++) begin
               if (s1_therm_q[i]) begin
                  enc_bin = BW'(i + 1);
               end
            end
         end
      end else begin : g_bad_impl
         $fatal(1, "thermometer2binary: unsupported IMPLEMENTATION string");
      end
   endgenerate

   // Next-state for both stages; data registers only move when their stage loads
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_therm_d   = s1_therm_q;
      out_valid_d  = out_valid_q;
      out_binary_d = out_binary_q;
      out_error_d  = out_error_q;
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_therm_d = in_thermometer;
         end
      end
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_binary_d = enc_bin;
            out_error_d  = enc_err;
         end
      end
   end

   // Pipeline registers; reset discards everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_therm_q   <= '0;
         out_valid_q  <= 1'b0;
         out_binary_q <= '0;
         out_error_q  <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_therm_q   <= s1_therm_d;
         out_valid_q  <= out_valid_d;
         out_binary_q <= out_binary_d;
         out_error_q  <= out_error_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_binary = out_binary_q;
   assign out_error  = out_error_q;

`ifdef THERMOMETER2BINARY_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Saturating count of emitted malformed words; clear wins over increment
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clear) begin
         err_cnt_d = '0;
      end else if (out_valid_q && out_ready && out_error_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Error counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_thermometer2binary.sv
// Bench for thermometer2binary: WIDTH=4 and WIDTH=7 pairs (COUNT and PRIORITY) fed identical stimulus.
// Expected results are queued when a word is accepted and popped by per-instance monitors on output transfers.
// Directed cases cover reset, latency, malformed codes, backpressure, mid-stream reset; random traffic covers WIDTH=7.
module tb_thermometer2binary;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   typedef struct {
      int bin;
      int err;
   } exp_t;

   int n_cmp  = 0;
   int n_fail = 0;

   // Group A: WIDTH=4
   logic       a_iv, a_ordy;
   logic [3:0] a_dat;
   logic       a_ir_c, a_ov_c, a_err_c, a_ir_p, a_ov_p, a_err_p;
   logic [2:0] a_bin_c, a_bin_p;
   // Group B: WIDTH=7
   logic       b_iv, b_ordy;
   logic [6:0] b_dat;
   logic       b_ir_c, b_ov_c, b_err_c, b_ir_p, b_ov_p, b_err_p;
   logic [2:0] b_bin_c, b_bin_p;
`ifdef THERMOMETER2BINARY_ERRCNT_EN
   logic        a_eclr, b_eclr;
   logic [15:0] a_ecnt_c, a_ecnt_p, b_ecnt_c, b_ecnt_p;
`endif

   thermometer2binary #(.WIDTH(4), .IMPLEMENTATION("COUNT")) dut_a_c (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir_c), .in_thermometer(a_dat),
      .out_valid(a_ov_c), .out_ready(a_ordy), .out_binary(a_bin_c), .out_error(a_err_c)
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      , .err_clear(a_eclr), .err_count(a_ecnt_c)
`endif
   );
   thermometer2binary #(.WIDTH(4), .IMPLEMENTATION("PRIORITY")) dut_a_p (
      .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir_p), .in_thermometer(a_dat),
      .out_valid(a_ov_p), .out_ready(a_ordy), .out_binary(a_bin_p), .out_error(a_err_p)
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      , .err_clear(a_eclr), .err_count(a_ecnt_p)
`endif
   );
   thermometer2binary #(.WIDTH(7), .IMPLEMENTATION("COUNT")) dut_b_c (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir_c), .in_thermometer(b_dat),
      .out_valid(b_ov_c), .out_ready(b_ordy), .out_binary(b_bin_c), .out_error(b_err_c)
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      , .err_clear(b_eclr), .err_count(b_ecnt_c)
`endif
   );
   thermometer2binary #(.WIDTH(7), .IMPLEMENTATION("PRIORITY")) dut_b_p (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir_p), .in_thermometer(b_dat),
      .out_valid(b_ov_p), .out_ready(b_ordy), .out_binary(b_bin_p), .out_error(b_err_p)
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      , .err_clear(b_eclr), .err_count(b_ecnt_p)
`endif
   );

   // Reference model: counting ones, bit length of the value, and the thermometer shape test
   function automatic int ref_count(input int w);
      return $countones(w);
   endfunction
   function automatic int ref_prio(input int w);
      int n = 0;
      while ((1 << n) <= w) n++;
      return n;
   endfunction
   function automatic int ref_illegal(input int w);
      return (w != ((1 << $countones(w)) - 1)) ? 1 : 0;
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   exp_t qa_c[$], qa_p[$], qb_c[$], qb_p[$];
   int na_out = 0, nb_out = 0;

   // Scoreboard push side: expected result recorded when a word is accepted
   always @(negedge clk) begin
      exp_t e;
      if (!rst && a_iv && a_ir_c) begin
         e.bin = ref_count(int'(a_dat)); e.err = ref_illegal(int'(a_dat)); qa_c.push_back(e);
         e.bin = ref_prio(int'(a_dat));  qa_p.push_back(e);
      end
      if (!rst && b_iv && b_ir_c) begin
         e.bin = ref_count(int'(b_dat)); e.err = ref_illegal(int'(b_dat)); qb_c.push_back(e);
         e.bin = ref_prio(int'(b_dat));  qb_p.push_back(e);
      end
   end

   // Monitors: compare each output transfer against the oldest expected entry
   always @(negedge clk) begin
      exp_t e;
      if (!rst && a_ov_c && a_ordy) begin
         na_out++;
         if (qa_c.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL a_cnt_extra: got word %0d, required none", a_bin_c);
         end else begin
            e = qa_c.pop_front();
            cmp("a_cnt_bin", int'(a_bin_c), e.bin);
            cmp("a_cnt_err", int'(a_err_c), e.err);
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (!rst && a_ov_p && a_ordy) begin
         if (qa_p.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL a_pri_extra: got word %0d, required none", a_bin_p);
         end else begin
            e = qa_p.pop_front();
            cmp("a_pri_bin", int'(a_bin_p), e.bin);
            cmp("a_pri_err", int'(a_err_p), e.err);
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (!rst && b_ov_c && b_ordy) begin
         nb_out++;
         if (qb_c.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL b_cnt_extra: got word %0d, required none", b_bin_c);
         end else begin
            e = qb_c.pop_front();
            cmp("b_cnt_bin", int'(b_bin_c), e.bin);
            cmp("b_cnt_err", int'(b_err_c), e.err);
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (!rst && b_ov_p && b_ordy) begin
         if (qb_p.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL b_pri_extra: got word %0d, required none", b_bin_p);
         end else begin
            e = qb_p.pop_front();
            cmp("b_pri_bin", int'(b_bin_p), e.bin);
            cmp("b_pri_err", int'(b_err_p), e.err);
         end
      end
   end

   // Present one word to group A and return just after the edge that accepts it
   task automatic a_send(input logic [3:0] w);
      bit ok;
      ok = 1'b0;
      a_iv  = 1'b1;
      a_dat = w;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = a_ir_c;
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL a_send_timeout: in_ready got 0, required 1");
      end
      @(posedge clk); #1;
      a_iv = 1'b0;
   endtask

   // Send one word with out_ready high, check both encodings when it appears, then let it drain
   task automatic a_single(input logic [3:0] w, input int ec, input int ep, input int ee);
      bit seen;
      seen = 1'b0;
      a_send(w);
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = a_ov_c;
      end
      cmp("single_seen", int'(seen), 1);
      cmp("single_cnt_bin", int'(a_bin_c), ec);
      cmp("single_pri_bin", int'(a_bin_p), ep);
      cmp("single_cnt_err", int'(a_err_c), ee);
      cmp("single_pri_err", int'(a_err_p), ee);
      @(posedge clk); #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int sent;
      int cyc;
      bit acc;
      bit drained;
      rst = 1'b1;
      a_iv = 1'b0; a_dat = '0; a_ordy = 1'b0;
      b_iv = 1'b0; b_dat = '0; b_ordy = 1'b0;
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      a_eclr = 1'b0; b_eclr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state, and in_ready high in the cycle after reset release
      @(negedge clk);
      cmp("rst_out_valid", int'(a_ov_c), 0);
      cmp("rst_out_binary", int'(a_bin_c), 0);
      cmp("rst_out_error", int'(a_err_c), 0);
      cmp("rst_in_ready", int'(a_ir_c), 1);
      cmp("rst_b_out_valid", int'(b_ov_c), 0);
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      cmp("rst_err_count", int'(a_ecnt_c), 0);
`endif

      // Back-to-back legal stream; word registered in S1 at accept, visible from S2 after the next edge
      @(posedge clk); #1;
      a_ordy = 1'b1;
      a_iv = 1'b1; a_dat = 4'b0000;
      @(posedge clk); #1;
      cmp("lat_not_yet", int'(a_ov_c), 0);
      a_dat = 4'b0001;
      @(posedge clk); #1;
      cmp("lat_first_valid", int'(a_ov_c), 1);
      cmp("stream_0", int'(a_bin_c), 0);
      a_dat = 4'b0011;
      @(posedge clk); #1;
      cmp("stream_1", int'(a_bin_c), 1);
      a_dat = 4'b0111;
      @(posedge clk); #1;
      cmp("stream_2", int'(a_bin_c), 2);
      cmp("stream_in_ready", int'(a_ir_c), 1);
      a_dat = 4'b1111;
      @(posedge clk); #1;
      cmp("stream_3", int'(a_bin_c), 3);
      a_iv = 1'b0;
      @(posedge clk); #1;
      cmp("stream_4", int'(a_bin_c), 4);
      cmp("stream_4_err", int'(a_err_c), 0);
      @(posedge clk); #1;
      cmp("stream_drained", int'(a_ov_c), 0);

      // Malformed and boundary codes
      a_single(4'b1011, 3, 4, 1);
      a_single(4'b0100, 1, 3, 1);
      a_single(4'b0110, 2, 3, 1);
      a_single(4'b1111, 4, 4, 0);
      a_single(4'b0000, 0, 0, 0);
`ifdef THERMOMETER2BINARY_ERRCNT_EN
      cmp("errcnt_three", int'(a_ecnt_c), 3);
      // Clear coinciding with an illegal emit
      a_send(4'b0100);
      drained = 1'b0;
      for (int k = 0; k < 10 && !drained; k++) begin
         @(negedge clk);
         drained = a_ov_c;
      end
      a_eclr = 1'b1;
      @(posedge clk); #1;
      a_eclr = 1'b0;
      cmp("errcnt_clear_wins", int'(a_ecnt_c), 0);
`endif

      // Backpressure: two words in flight, output held for five cycles
      a_ordy = 1'b0;
      base = na_out;
      a_send(4'b0001);
      a_send(4'b0011);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         cmp("bp_in_ready", int'(a_ir_c), 0);
         cmp("bp_out_valid", int'(a_ov_c), 1);
         cmp("bp_out_binary", int'(a_bin_c), 1);
      end
      @(posedge clk); #1;
      a_ordy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      cmp("bp_emitted", na_out - base, 2);
      cmp("bp_queue_empty", qa_c.size(), 0);

      // Reset with two words in flight
      a_ordy = 1'b0;
      a_send(4'b0111);
      a_send(4'b1111);
      rst = 1'b1;
      qa_c.delete(); qa_p.delete(); qb_c.delete(); qb_p.delete();
      @(posedge clk); #1;
      cmp("midrst_out_valid", int'(a_ov_c), 0);
      rst = 1'b0;
      a_ordy = 1'b1;
      base = na_out;
      @(negedge clk);
      cmp("midrst_in_ready", int'(a_ir_c), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cmp("midrst_no_stale", int'(a_ov_c), 0);
      end
      cmp("midrst_emitted", na_out - base, 0);

      // Random handshake traffic on WIDTH=7, 1000 words
      @(posedge clk); #1;
      sent = 0;
      base = nb_out;
      cyc = 0;
      while (sent < 1000 && cyc < 20000) begin
         @(negedge clk);
         acc = b_iv && b_ir_c;
         if (acc) sent++;
         @(posedge clk); #1;
         cyc++;
         b_ordy = ($urandom_range(0, 3) != 0);
         if (!b_iv || acc) begin
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
               b_iv = 1'b1;
               if ($urandom_range(0, 1) == 1)
                  b_dat = 7'((1 << $urandom_range(0, 7)) - 1);
               else
                  b_dat = 7'($urandom_range(0, 127));
            end else begin
               b_iv = 1'b0;
            end
         end
      end
      b_iv = 1'b0;
      b_ordy = 1'b1;
      drained = 1'b0;
      for (int k = 0; k < 100 && !drained; k++) begin
         @(negedge clk);
         drained = (qb_c.size() == 0) && (qb_p.size() == 0) && !b_ov_c;
      end
      cmp("rand_sent", sent, 1000);
      cmp("rand_emitted", nb_out - base, 1000);
      cmp("rand_drained", int'(drained), 1);

`ifdef THERMOMETER2BINARY_ERRCNT_EN
      // Saturation: 65540 illegal words emitted back-to-back
      @(posedge clk); #1;
      a_ordy = 1'b1;
      a_iv = 1'b1; a_dat = 4'b1011;
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1 a_iv = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      cmp("errcnt_saturate", int'(a_ecnt_c), 16'hFFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
